morph_dilate: RTL and testbench

//  3x3 binary dilation for the pixel-stream morphology chain; dual of the erosion stage, used after it for opening.
//  An output pixel is 1 if any in-frame tap of its window is 1. Taps outside the frame read as 0.

---
 rtl/morph_dilate_pkg.sv | 26 ++
 rtl/morph_dilate_line_buffer.sv | 30 +++
 rtl/morph_dilate.sv | 170 +++++++++++++++++
 tb/tb_morph_dilate.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/morph_dilate_pkg.sv
// Shared constants, window type and mask helpers for the binary dilation stage.
// Build option MORPH_DILATE_CROSS_EN selects a plus-shaped structuring element instead of the 3x3 square.
package morph_pkg;

  localparam int DEF_IMG_WIDTH  = 640;
  localparam int DEF_IMG_HEIGHT = 480;
  localparam int COL_W          = $clog2(DEF_IMG_WIDTH);
  localparam int ROW_SAT        = 2;

  // Indexed [column age][row age]; age 0 is the newest column and the current row.
  typedef logic [2:0][2:0] win_t;

  function automatic win_t se_mask();
`ifdef MORPH_DILATE_CROSS_EN
    se_mask = {3'b010, 3'b111, 3'b010};
`else
    se_mask = {3'b111, 3'b111, 3'b111};
`endif
  endfunction

  // A tap k steps back is inside the frame once the saturated position has reached k.
  function automatic logic [2:0] age_keep(input logic [1:0] pos_sat);
    age_keep = {(pos_sat >= 2'd2), (pos_sat >= 2'd1), 1'b1};
  endfunction

endpackage

// File: rtl/morph_dilate_line_buffer.sv
// Two-line pixel delay feeding the dilation window: tap1 is the row above, tap0 two rows above.
module dilate_line_buffer
  import morph_pkg::*;
#(
  parameter int DEPTH = DEF_IMG_WIDTH,
  parameter int AW    = COL_W
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic          din,
  output logic          tap0,
  output logic          tap1
);

  logic line1_q [DEPTH];
  logic line0_q [DEPTH];

  assign tap1 = line1_q[addr];
  assign tap0 = line0_q[addr];

  // Each column cascades one line down per valid beat; stale contents are hidden by row masking.
  always_ff @(posedge clk) begin
    if (we) begin
      line1_q[addr] <= din;
      line0_q[addr] <= line1_q[addr];
    end
  end

endmodule

// File: rtl/morph_dilate.sv
// 3x3 binary dilation on a raster pixel stream; output trails the input by exactly two cycles.
// Build option MORPH_DILATE_CROSS_EN: plus-shaped element (corners ignored) instead of the full square.
module morph_dilate
  import morph_pkg::*;
#(
  parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
  parameter int DATA_WIDTH = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_in_valid,
  input  logic                  data_in_hs,
  input  logic                  data_in_vs,
  output logic                  data_out,
  output logic                  data_out_valid,
  output logic                  data_out_hs,
  output logic                  data_out_vs
);

  localparam int CW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam int ROW_LIMIT = ((IMG_HEIGHT - 1) < ROW_SAT) ? (IMG_HEIGHT - 1) : ROW_SAT;
  localparam logic [1:0] ROW_TOP = 2'(ROW_LIMIT);

  logic          vs_rise;
  logic [CW-1:0] col_pos;
  logic [1:0]    row_pos;
  logic [1:0]    col_sat;
  logic          tap0;
  logic          tap1;
  win_t          se;
  win_t          masked;
  logic [2:0]    col_keep;
  logic [2:0]    row_keep;
  logic          hit;

  logic          vs_q,        vs_d;
  logic [CW-1:0] col_q,       col_d;
  logic [1:0]    row_q,       row_d;
  logic          armed_q,     armed_d;
  win_t          win_q,       win_d;
  logic [1:0]    col_m_q,     col_m_d;
  logic [1:0]    row_m_q,     row_m_d;
  logic          vld1_q,      vld1_d;
  logic          arm1_q,      arm1_d;
  logic          out_q,       out_d;
  logic          out_vld_q,   out_vld_d;
  logic [1:0]    hs_dly_q,    hs_dly_d;
  logic [1:0]    vs_dly_q,    vs_dly_d;

  dilate_line_buffer #(
    .DEPTH (IMG_WIDTH),
    .AW    (CW)
  ) u_lbuf (
    .clk  (clk),
    .we   (data_in_valid),
    .addr (col_pos),
    .din  (data_in[0]),
    .tap0 (tap0),
    .tap1 (tap1)
  );

  // Frame-start override, pixel position of the current beat and counter advance.
  always_comb begin
    vs_rise = data_in_vs & ~vs_q;
    vs_d    = data_in_vs;
    col_pos = vs_rise ? {CW{1'b0}} : col_q;
    row_pos = vs_rise ? 2'd0 : row_q;
    armed_d = vs_rise ? 1'b1 : armed_q;
    col_sat = (col_pos >= CW'(2)) ? 2'd2 : col_pos[1:0];
    col_d   = col_pos;
    row_d   = row_pos;
    if (data_in_valid) begin
      if (col_pos == COL_LAST) begin
        col_d = {CW{1'b0}};
        row_d = (row_pos >= ROW_TOP) ? ROW_TOP : row_pos + 2'd1;
      end else begin
        col_d = col_pos + CW'(1);
        row_d = row_pos;
      end
    end else begin
      col_d = col_pos;
      row_d = row_pos;
    end
  end

  // Window shift plus the position it was taken at, which drives the edge masks.
  always_comb begin
    win_d   = win_q;
    col_m_d = col_m_q;
    row_m_d = row_m_q;
    if (data_in_valid) begin
      win_d   = {win_q[1], win_q[0], {tap0, tap1, data_in[0]}};
      col_m_d = col_sat;
      row_m_d = row_pos;
    end else begin
      win_d   = win_q;
      col_m_d = col_m_q;
      row_m_d = row_m_q;
    end
  end

  // Masked OR over the window; out-of-frame taps never contribute.
  always_comb begin
    se       = se_mask();
    col_keep = age_keep(col_m_q);
    row_keep = age_keep(row_m_q);
    masked   = 9'b0;
    hit      = 1'b0;
    for (int k = 0; k < 3; k++) begin
      masked[k] = win_q[k] & se[k] & row_keep & (col_keep[k] ? 3'b111 : 3'b000);
      hit       = hit | (|masked[k]);
    end
  end

  // Output stage and sync delays; data_out holds between valid results.
  always_comb begin
    vld1_d    = data_in_valid;
    arm1_d    = armed_d;
    out_vld_d = vld1_q & arm1_q;
    hs_dly_d  = {hs_dly_q[0], data_in_hs};
    vs_dly_d  = {vs_dly_q[0], data_in_vs};
    if (vld1_q) begin
      out_d = hit;
    end else begin
      out_d = out_q;
    end
  end

  // All state of the stage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vs_q      <= 1'b0;
      col_q     <= {CW{1'b0}};
      row_q     <= 2'd0;
      armed_q   <= 1'b0;
      win_q     <= 9'b0;
      col_m_q   <= 2'd0;
      row_m_q   <= 2'd0;
      vld1_q    <= 1'b0;
      arm1_q    <= 1'b0;
      out_q     <= 1'b0;
      out_vld_q <= 1'b0;
      hs_dly_q  <= 2'd0;
      vs_dly_q  <= 2'd0;
    end else begin
      vs_q      <= vs_d;
      col_q     <= col_d;
      row_q     <= row_d;
      armed_q   <= armed_d;
      win_q     <= win_d;
      col_m_q   <= col_m_d;
      row_m_q   <= row_m_d;
      vld1_q    <= vld1_d;
      arm1_q    <= arm1_d;
      out_q     <= out_d;
      out_vld_q <= out_vld_d;
      hs_dly_q  <= hs_dly_d;
      vs_dly_q  <= vs_dly_d;
    end
  end

  assign data_out       = out_q;
  assign data_out_valid = out_vld_q;
  assign data_out_hs    = hs_dly_q[1];
  assign data_out_vs    = vs_dly_q[1];

endmodule

// File: tb/tb_morph_dilate.sv
// Self-checking bench for morph_dilate on a 16x8 frame: image-based reference model feeding a scoreboard.
`timescale 1ns/1ps
module tb_morph_dilate;

  localparam int W = 16;
  localparam int H = 8;
`ifdef MORPH_DILATE_CROSS_EN
  localparam int ONES_SINGLE  = 5;
  localparam int ONES_LASTCOL = 1;
  localparam int ONES_LASTROW = 15;
  localparam int ONES_ALL     = W * H - 1;
`else
  localparam int ONES_SINGLE  = 9;
  localparam int ONES_LASTCOL = 3;
  localparam int ONES_LASTROW = 16;
  localparam int ONES_ALL     = W * H;
`endif

  typedef struct { logic val; int due; int r; int c; int fid; } exp_t;
  typedef struct { string name; int pat; int npix; bit gaps; bit hsvs; int ones; } vec_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [0:0] data_in;
  logic       data_in_valid;
  logic       data_in_hs;
  logic       data_in_vs;
  logic       data_out;
  logic       data_out_valid;
  logic       data_out_hs;
  logic       data_out_vs;

  int         cyc = 0;
  int         total = 0;
  int         bad = 0;
  exp_t       sbq[$];
  logic       img [H][W];
  int         ones_cnt [64];
  int         fid = 0;
  int         valid_seen = 0;
  bit         hsvs_on = 1'b0;
  logic [1:0] hist [4];
  vec_t       vt [6];

  morph_dilate #(
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H),
    .DATA_WIDTH (1)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .data_in        (data_in),
    .data_in_valid  (data_in_valid),
    .data_in_hs     (data_in_hs),
    .data_in_vs     (data_in_vs),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .data_out_hs    (data_out_hs),
    .data_out_vs    (data_out_vs)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic model_px(int r, int c);
    logic acc = 1'b0;
    for (int dr = 0; dr < 3; dr++) begin
      for (int dc = 0; dc < 3; dc++) begin
        bit in_se;
`ifdef MORPH_DILATE_CROSS_EN
        in_se = (dr == 1) || (dc == 1);
`else
        in_se = 1'b1;
`endif
        if (in_se && (r - dr) >= 0 && (c - dc) >= 0) acc = acc | img[r - dr][c - dc];
      end
    end
    return acc;
  endfunction

  task automatic fill_img(int pat);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        case (pat)
          1:       img[r][c] = (r == 5 && c == 5);
          2:       img[r][c] = (r == 3 && c == W - 1);
          3:       img[r][c] = (r == H - 1);
          4:       img[r][c] = 1'b1;
          default: img[r][c] = 1'b0;
        endcase
      end
    end
  endtask

  task automatic idle();
    data_in_valid = 1'b0;
    data_in_hs    = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic beat(int r, int c, logic vs, logic hs, bit push);
    data_in       = img[r][c];
    data_in_valid = 1'b1;
    data_in_vs    = vs;
    data_in_hs    = hs;
    if (push) sbq.push_back('{model_px(r, c), cyc + 2, r, c, fid});
    @(posedge clk); #1;
    data_in_valid = 1'b0;
    data_in_hs    = 1'b0;
  endtask

  task automatic run_frame(int npix, bit gaps, bit push);
    fid = fid + 1;
    ones_cnt[fid] = 0;
    for (int i = 0; i < npix; i++) begin
      if (gaps && i > 0 && $urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 5)) idle();
      end
      beat(i / W, i % W, (i / W) == 0, (i % W) == 0, push);
    end
  endtask

  task automatic drain(string name);
    int n = 0;
    data_in_vs = 1'b0;
    while (sbq.size() != 0 && n < 20) begin
      idle();
      n++;
    end
    idle();
    idle();
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL %s drain: %0d outputs still pending, required 0", name, sbq.size());
      sbq.delete();
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (data_out_valid) begin
          valid_seen++;
          total++;
          if (sbq.size() == 0) begin
            bad++;
            $display("FAIL unexpected_out: cycle %0d data_out=%0b, required no valid output", cyc, data_out);
          end else begin
            e = sbq.pop_front();
            ones_cnt[e.fid] += int'(data_out);
            if (data_out !== e.val || cyc != e.due) begin
              bad++;
              $display("FAIL pixel(%0d,%0d) frame %0d: got %0b at cycle %0d, required %0b at cycle %0d",
                       e.r, e.c, e.fid, data_out, cyc, e.val, e.due);
            end
          end
        end
        if (hsvs_on && cyc >= 2) begin
          total++;
          if ({data_out_hs, data_out_vs} !== hist[(cyc - 2) % 4]) begin
            bad++;
            $display("FAIL sync_delay: cycle %0d hs/vs=%b, required %b", cyc,
                     {data_out_hs, data_out_vs}, hist[(cyc - 2) % 4]);
          end
        end
        hist[cyc % 4] = {data_in_hs, data_in_vs};
      end
    end
  endtask

  initial begin
    int rnd;
    int vs0;
    vt[0] = '{"single_5_5",     1, W * H, 1'b0, 1'b0, ONES_SINGLE};
    vt[1] = '{"last_col",       2, W * H, 1'b0, 1'b0, ONES_LASTCOL};
    vt[2] = '{"frameA_lastrow", 3, W * H, 1'b0, 1'b0, ONES_LASTROW};
    vt[3] = '{"frameB_zero",    0, W * H, 1'b0, 1'b0, 0};
    vt[4] = '{"all_ones",       4, W * H, 1'b0, 1'b1, ONES_ALL};
    vt[5] = '{"gapped",         1, W * H, 1'b1, 1'b0, ONES_SINGLE};
    for (int i = 0; i < 4; i++) hist[i] = 2'b00;
    data_in       = 1'b0;
    data_in_valid = 1'b0;
    data_in_hs    = 1'b0;
    data_in_vs    = 1'b0;
    reset_n       = 1'b1;
    #2 reset_n    = 1'b0;
    fork
      monitor();
    join_none
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({data_out, data_out_valid, data_out_hs, data_out_vs} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_state: outputs=%b, required 0000",
               {data_out, data_out_valid, data_out_hs, data_out_vs});
    end
    reset_n = 1'b1;
    idle();
    idle();
    rnd = $urandom(1);

    for (int i = 0; i < 6; i++) begin
      fill_img(vt[i].pat);
      hsvs_on = vt[i].hsvs;
      run_frame(vt[i].npix, vt[i].gaps, 1'b1);
      drain(vt[i].name);
      hsvs_on = 1'b0;
      total++;
      if (ones_cnt[fid] != vt[i].ones) begin
        bad++;
        $display("FAIL %s ones: got %0d, required %0d", vt[i].name, ones_cnt[fid], vt[i].ones);
      end
    end

    // vs edge together with the last pixel of a frame: that pixel restarts at (0,0).
    fill_img(4);
    run_frame(W * H - 1, 1'b0, 1'b1);
    fill_img(1);
    run_frame(W * H, 1'b0, 1'b1);
    drain("vs_on_last_px");
    total++;
    if (ones_cnt[fid] != ONES_SINGLE) begin
      bad++;
      $display("FAIL vs_on_last_px ones: got %0d, required %0d", ones_cnt[fid], ONES_SINGLE);
    end

    // Reset mid-frame: immediate drop, then no valid output until the next frame start.
    fill_img(4);
    fid = fid + 1;
    ones_cnt[fid] = 0;
    for (int i = 0; i < 40; i++) beat(i / W, i % W, (i / W) == 0, (i % W) == 0, 1'b1);
    reset_n = 1'b0;
    #1;
    total++;
    if ({data_out, data_out_valid, data_out_hs, data_out_vs} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_async: outputs=%b, required 0000",
               {data_out, data_out_valid, data_out_hs, data_out_vs});
    end
    sbq.delete();
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    vs0 = valid_seen;
    for (int i = 40; i < W * H; i++) beat(i / W, i % W, 1'b0, (i % W) == 0, 1'b0);
    idle();
    idle();
    idle();
    total++;
    if (valid_seen != vs0) begin
      bad++;
      $display("FAIL reset_unarmed: got %0d valid outputs, required 0", valid_seen - vs0);
    end
    fill_img(1);
    run_frame(W * H, 1'b0, 1'b1);
    drain("after_reset");
    total++;
    if (ones_cnt[fid] != ONES_SINGLE) begin
      bad++;
      $display("FAIL after_reset ones: got %0d, required %0d", ones_cnt[fid], ONES_SINGLE);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
